// File: rtl/button_debounce_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce_fsm
//  Description : Synchronises a raw button level, accepts a new level after
//                N_STABLE stable sample ticks, and counts accepted presses.
//  Revision    : 1.0  initial release
// ============================================================================
module button_debounce_fsm #(
    parameter int N_STABLE = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_s_n,
    input  logic             sample_tick,
    input  logic             btn_in,
    output logic             btn_level,
    output logic             btn_rise,
    output logic             btn_fall,
    output logic [CNT_W-1:0] press_count
);

    localparam int c_STAB_W = $clog2(N_STABLE + 1);
    localparam logic [c_STAB_W-1:0] c_STAB_LAST = c_STAB_W'(N_STABLE - 1);

    localparam logic [1:0] S_LOW      = 2'd0;
    localparam logic [1:0] S_CHK_HIGH = 2'd1;
    localparam logic [1:0] S_HIGH     = 2'd2;
    localparam logic [1:0] S_CHK_LOW  = 2'd3;

    logic [1:0]          r_state;
    logic [c_STAB_W-1:0] r_stab_cnt;
    logic                r_sync1;
    logic                r_sync2;
    logic                r_level;
    logic                r_rise;
    logic                r_fall;
    logic [CNT_W-1:0]    r_press_count;

    // A level mismatch is tested before sample_tick so an abort always wins.
    always_ff @(posedge clk) begin
        if (!rst_s_n) begin
            r_state       <= S_LOW;
            r_stab_cnt    <= '0;
            r_sync1       <= 1'b0;
            r_sync2       <= 1'b0;
            r_level       <= 1'b0;
            r_rise        <= 1'b0;
            r_fall        <= 1'b0;
            r_press_count <= '0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            case (r_state)
                S_LOW: begin
                    if (r_sync2) begin
                        r_state    <= S_CHK_HIGH;
                        r_stab_cnt <= '0;
                    end
                end
                S_CHK_HIGH: begin
                    if (!r_sync2) begin
                        r_state    <= S_LOW;
                        r_stab_cnt <= '0;
                    end else if (sample_tick) begin
                        if (r_stab_cnt == c_STAB_LAST) begin
                            r_state       <= S_HIGH;
                            r_stab_cnt    <= '0;
                            r_level       <= 1'b1;
                            r_rise        <= 1'b1;
                            r_press_count <= r_press_count + CNT_W'(1);
                        end else begin
                            r_stab_cnt <= r_stab_cnt + c_STAB_W'(1);
                        end
                    end
                end
                S_HIGH: begin
                    if (!r_sync2) begin
                        r_state    <= S_CHK_LOW;
                        r_stab_cnt <= '0;
                    end
                end
                S_CHK_LOW: begin
                    if (r_sync2) begin
                        r_state    <= S_HIGH;
                        r_stab_cnt <= '0;
                    end else if (sample_tick) begin
                        if (r_stab_cnt == c_STAB_LAST) begin
                            r_state    <= S_LOW;
                            r_stab_cnt <= '0;
                            r_level    <= 1'b0;
                            r_fall     <= 1'b1;
                        end else begin
                            r_stab_cnt <= r_stab_cnt + c_STAB_W'(1);
                        end
                    end
                end
                default: begin
                    r_state    <= S_LOW;
                    r_stab_cnt <= '0;
                end
            endcase
        end
    end

    assign btn_level   = r_level;
    assign btn_rise    = r_rise;
    assign btn_fall    = r_fall;
    assign press_count = r_press_count;

endmodule
`default_nettype wire

// File: doc/button_debounce_fsm.md
BUTTON_DEBOUNCE_FSM -- requirements
Module: button_debounce_fsm

Interface
REQ-001 SHALL have parameter N_STABLE, default 4: number of consecutive sample ticks with a stable level needed to accept that level; legal range 1..255.
REQ-002 SHALL have parameter CNT_W, default 8: width of press_count.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst_s_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port sample_tick  input  1  one-cycle strobe from the upstream tick counter (its match output).
REQ-006 SHALL have port btn_in  input  1  raw, asynchronous, bouncing button level.
REQ-007 SHALL have port btn_level  output  1  debounced level, registered.
REQ-008 SHALL have port btn_rise  output  1  one-cycle pulse when the accepted level goes 0->1.
REQ-009 SHALL have port btn_fall  output  1  one-cycle pulse when the accepted level goes 1->0.
REQ-010 SHALL have port press_count  output  CNT_W  count of accepted rises, wraps modulo 2^CNT_W.

Function
REQ-011 SHALL pass btn_in through a 2-flop synchronizer (btn_sync = second flop), giving 2 cycles of latency before the FSM sees it.
REQ-012 SHALL implement FSM states S_LOW, S_CHK_HIGH, S_HIGH, S_CHK_LOW, plus a stability counter stab_cnt of width ceil(log2(N_STABLE+1)).
REQ-013 In S_LOW, if btn_sync=1: next state S_CHK_HIGH and stab_cnt<=0; otherwise hold.
REQ-014 In S_CHK_HIGH, if btn_sync=0: return to S_LOW with stab_cnt<=0 (bounce reject); outputs unchanged.
REQ-015 In S_CHK_HIGH, if btn_sync=1 and sample_tick=1: when stab_cnt=N_STABLE-1, go to S_HIGH; otherwise increment stab_cnt.
REQ-016 In S_CHK_HIGH, if btn_sync=1 and sample_tick=0: hold state and stab_cnt.
REQ-017 S_HIGH and S_CHK_LOW SHALL mirror REQ-013..016 with polarity inverted; acceptance goes to S_LOW.
REQ-018 On the same cycle, a level mismatch (abort) SHALL take precedence over sample_tick.
REQ-019 On entry to S_HIGH: btn_level<=1, btn_rise<=1 for exactly one cycle, and press_count<=press_count+1, all in the same clock edge.
REQ-020 On entry to S_LOW from S_CHK_LOW: btn_level<=0 and btn_fall<=1 for exactly one cycle.
REQ-021 btn_rise and btn_fall SHALL never be high together, and SHALL be low in every cycle not covered by REQ-019/020.
REQ-022 Acceptance latency: outputs change on the clock edge that samples the N_STABLE-th qualifying sample_tick; the tick on which the FSM enters S_CHK_* is not counted.
REQ-023 If sample_tick is held high continuously, it SHALL count once per cycle; with N_STABLE=1, one tick suffices.
REQ-024 press_count SHALL wrap from 2^CNT_W-1 to 0 with no flag.

Reset
REQ-025 When rst_s_n=0 at a rising edge, the block SHALL clear: state S_LOW, stab_cnt=0, sync flops=0, btn_level=0, btn_rise=0, btn_fall=0, press_count=0.
REQ-026 Reset SHALL override all other activity, including mid-check and an acceptance in the same cycle; no pulse is emitted on that edge or on release.
REQ-027 After reset release with btn_in held high, the block SHALL perform a normal rise acceptance; it SHALL NOT preload the level.

Verification (N_STABLE=4, sample_tick every 5th cycle unless stated)
REQ-028 btn_in 0->1 held stable -> btn_rise pulses 1 cycle on the 4th tick after S_CHK_HIGH entry; btn_level=1; press_count=1.
REQ-029 btn_in high for 3 ticks, low 2 cycles, then high -> no rise until 4 further qualifying ticks; press_count counts only 1.
REQ-030 Abort and tick in the same cycle while in S_CHK_LOW -> return to S_HIGH, btn_level stays 1, no btn_fall.
REQ-031 sample_tick tied to 1, N_STABLE=1 -> rise accepted 1 cycle after btn_sync=1 entry into S_CHK_HIGH.
REQ-032 CNT_W=2, 5 clean presses -> press_count sequence 1,2,3,0,1.
REQ-033 rst_s_n=0 asserted on the acceptance edge -> all outputs 0, no pulse; btn_in still high after release -> fresh 4-tick acceptance.
